// File: rtl/laser_mem_pkg.sv
`default_nettype none
// ============================================================================
// Package     : laser_mem_pkg
// Description : Shared types and constants for the Laser 350/500/700 memory
//               mapper. Holds the sequencer state encoding, the per-model
//               RAM window constants and the default slot-register I/O base.
// Revision    : 1.0 - initial release
// ============================================================================
package laser_mem_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DL_WAIT  = 2'd1,
    CPU_WAIT = 2'd2,
    DONE     = 2'd3
  } mem_state_t;

  // RAM windows per machine model (first writable page, number of pages)
  localparam int L350_RAM_FIRST_PAGE = 4;
  localparam int L350_RAM_PAGES      = 1;
  localparam int L500_RAM_FIRST_PAGE = 4;
  localparam int L500_RAM_PAGES      = 4;
  localparam int L700_RAM_FIRST_PAGE = 4;
  localparam int L700_RAM_PAGES      = 8;

  localparam logic [7:0] DEFAULT_IO_PORT_BASE = 8'h40;

endpackage
`default_nettype wire

// File: rtl/laser_slot_regs.sv
`default_nettype none
// ============================================================================
// Module      : laser_slot_regs
// Description : Slot page register file with Z80 I/O decode and readback.
//               Slot i lives at I/O port IO_PORT_BASE+i.
// Revision    : 1.0 - initial release
// Ports       : clk, reset_n        - clock, async active-low reset
//               io_port, io_wdata   - I/O port number and write data
//               iorq_n/rd_n/wr_n/m1_n - Z80 bus strobes
//               slot                - slot selected by the memory address
//               page                - page register of that slot
//               io_sel, io_rdata    - I/O read hit and readback byte
// ============================================================================
module laser_slot_regs
  import laser_mem_pkg::*;
#(
  parameter int         NUM_SLOTS    = 4,
  parameter int         PAGE_BITS    = 4,
  parameter logic [7:0] IO_PORT_BASE = DEFAULT_IO_PORT_BASE,
  localparam int        SLOT_BITS    = $clog2(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [7:0]           io_port,
  input  logic [PAGE_BITS-1:0] io_wdata,
  input  logic                 iorq_n,
  input  logic                 rd_n,
  input  logic                 wr_n,
  input  logic                 m1_n,
  input  logic [SLOT_BITS-1:0] slot,
  output logic [PAGE_BITS-1:0] page,
  output logic                 io_sel,
  output logic [7:0]           io_rdata
);

  logic [PAGE_BITS-1:0] pages [NUM_SLOTS];
  logic                 loaded;
  logic [8:0]           port_ofs;
  logic                 hit;
  logic [SLOT_BITS-1:0] idx;
  logic                 io_cycle;
  logic                 wr_hit;

  // Ports below the base wrap to >= 256 in 9 bits, so one compare covers
  // both ends of the window.
  assign port_ofs = {1'b0, io_port} - {1'b0, IO_PORT_BASE};
  assign hit      = (port_ofs < 9'(NUM_SLOTS));
  assign idx      = port_ofs[SLOT_BITS-1:0];
  assign io_cycle = !iorq_n && m1_n;
  // Only the first qualifying cycle of an IORQ assertion loads the register.
  assign wr_hit   = io_cycle && !wr_n && hit && !loaded;
  assign io_sel   = io_cycle && !rd_n && hit;
  assign page     = pages[slot];

  always_comb begin
    io_rdata                = '0;
    io_rdata[PAGE_BITS-1:0] = pages[idx];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      loaded <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) pages[i] <= '0;
    end else begin
      if (iorq_n)      loaded <= 1'b0;
      else if (wr_hit) loaded <= 1'b1;
      if (wr_hit) pages[idx] <= io_wdata;
    end
  end

endmodule
`default_nettype wire

// File: rtl/laser_bank_mapper.sv
`default_nettype none
// ============================================================================
// Module      : laser_bank_mapper
// Description : Memory mapper and SDRAM request sequencer for the Laser
//               350/500/700. Maps Z80 addresses through slot page registers,
//               write-protects non-RAM pages, drives WAIT_n from a req/ack
//               handshake and gives data_io downloads priority through a
//               one-entry holding buffer.
// Revision    : 1.0 - initial release
// Ports       : clk, reset_n                 - clock, async active-low reset
//               cpu_*                        - Z80 bus; cpu_din/wait_n/io_sel out
//               dl_wr/dl_addr/dl_data        - download byte strobe
//               dl_busy, dl_overrun          - buffer occupied / byte dropped
//               mem_req/we/addr/wdata        - SDRAM request (level)
//               mem_rdata, mem_ack           - SDRAM completion
//               rom_wr_err                   - suppressed ROM write pulse
// ============================================================================
module laser_bank_mapper
  import laser_mem_pkg::*;
#(
  parameter int         NUM_SLOTS      = 4,
  parameter int         PAGE_BITS      = 4,
  parameter int         PHYS_ADDR_W    = 25,
  parameter int         RAM_FIRST_PAGE = L500_RAM_FIRST_PAGE,
  parameter int         RAM_PAGES      = L500_RAM_PAGES,
  parameter logic [7:0] IO_PORT_BASE   = DEFAULT_IO_PORT_BASE
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [15:0]            cpu_addr,
  input  logic [7:0]             cpu_dout,
  input  logic                   cpu_mreq_n,
  input  logic                   cpu_iorq_n,
  input  logic                   cpu_rd_n,
  input  logic                   cpu_wr_n,
  input  logic                   cpu_m1_n,
  output logic [7:0]             cpu_din,
  output logic                   cpu_wait_n,
  output logic                   io_sel,
  input  logic                   dl_wr,
  input  logic [PHYS_ADDR_W-1:0] dl_addr,
  input  logic [7:0]             dl_data,
  output logic                   dl_busy,
  output logic                   dl_overrun,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [PHYS_ADDR_W-1:0] mem_addr,
  output logic [7:0]             mem_wdata,
  input  logic [7:0]             mem_rdata,
  input  logic                   mem_ack,
  output logic                   rom_wr_err
);

  localparam int SLOT_BITS = $clog2(NUM_SLOTS);
  localparam int OFS_BITS  = 16 - SLOT_BITS;
  // One extra bit so the upper window bound cannot wrap.
  localparam logic [PAGE_BITS:0] RAM_LO = (PAGE_BITS+1)'(RAM_FIRST_PAGE);
  localparam logic [PAGE_BITS:0] RAM_HI = (PAGE_BITS+1)'(RAM_FIRST_PAGE + RAM_PAGES);

  mem_state_t             state, state_nx;
  logic [SLOT_BITS-1:0]   slot;
  logic [PAGE_BITS-1:0]   page;
  logic [PAGE_BITS:0]     page_ext;
  logic                   is_ram;
  logic [PHYS_ADDR_W-1:0] phys;
  logic [7:0]             io_rdata;
  logic                   served, served_nx;
  logic                   access;
  logic [7:0]             din_q, din_nx;
  logic                   req_nx, we_nx;
  logic [PHYS_ADDR_W-1:0] addr_nx;
  logic [7:0]             wdata_nx;
  logic                   rom_err_nx;
  logic [PHYS_ADDR_W-1:0] dl_addr_q;
  logic [7:0]             dl_data_q;
  logic                   dl_clear, dl_accept, busy_nx, overrun_nx;

  laser_slot_regs #(
    .NUM_SLOTS    (NUM_SLOTS),
    .PAGE_BITS    (PAGE_BITS),
    .IO_PORT_BASE (IO_PORT_BASE)
  ) u_slot_regs (
    .clk      (clk),
    .reset_n  (reset_n),
    .io_port  (cpu_addr[7:0]),
    .io_wdata (cpu_dout[PAGE_BITS-1:0]),
    .iorq_n   (cpu_iorq_n),
    .rd_n     (cpu_rd_n),
    .wr_n     (cpu_wr_n),
    .m1_n     (cpu_m1_n),
    .slot     (slot),
    .page     (page),
    .io_sel   (io_sel),
    .io_rdata (io_rdata)
  );

  assign slot     = cpu_addr[15:OFS_BITS];
  assign page_ext = {1'b0, page};
  assign is_ram   = (page_ext >= RAM_LO) && (page_ext < RAM_HI);

  always_comb begin
    phys = '0;
    phys[PAGE_BITS+OFS_BITS-1:0] = {page, cpu_addr[OFS_BITS-1:0]};
  end

  assign access     = !cpu_mreq_n && (!cpu_rd_n || !cpu_wr_n) && !served;
  // Reset releases WAIT at once even if the CPU still holds MREQ.
  assign cpu_wait_n = !(reset_n && access && (state != DONE));
  assign cpu_din    = io_sel ? io_rdata : din_q;

  always_comb begin
    state_nx   = state;
    req_nx     = mem_req;
    we_nx      = mem_we;
    addr_nx    = mem_addr;
    wdata_nx   = mem_wdata;
    din_nx     = din_q;
    served_nx  = served;
    rom_err_nx = 1'b0;
    dl_clear   = 1'b0;
    unique case (state)
      IDLE: begin
        // A byte arriving this cycle is issued straight from the input so a
        // simultaneous CPU access still loses arbitration.
        if (dl_busy || dl_wr) begin
          req_nx   = 1'b1;
          we_nx    = 1'b1;
          addr_nx  = dl_busy ? dl_addr_q : dl_addr;
          wdata_nx = dl_busy ? dl_data_q : dl_data;
          state_nx = DL_WAIT;
        end else if (access && !cpu_wr_n && !is_ram) begin
          rom_err_nx = 1'b1;
          served_nx  = 1'b1;
          state_nx   = DONE;
        end else if (access) begin
          req_nx   = 1'b1;
          we_nx    = !cpu_wr_n;
          addr_nx  = phys;
          wdata_nx = cpu_dout;
          state_nx = CPU_WAIT;
        end
      end
      DL_WAIT: begin
        if (mem_ack) begin
          req_nx   = 1'b0;
          dl_clear = 1'b1;
          state_nx = IDLE;
        end
      end
      CPU_WAIT: begin
        if (mem_ack) begin
          req_nx    = 1'b0;
          served_nx = 1'b1;
          if (!mem_we) din_nx = mem_rdata;
          state_nx  = DONE;
        end
      end
      DONE: begin
        if (cpu_mreq_n) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (cpu_mreq_n) served_nx = 1'b0;
  end

  // Holding buffer: a slot freed by this cycle's ack may be refilled at once.
  assign dl_accept  = dl_wr && (!dl_busy || dl_clear);
  assign busy_nx    = dl_accept ? 1'b1 : (dl_clear ? 1'b0 : dl_busy);
  assign overrun_nx = dl_wr && dl_busy && !dl_clear;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      din_q      <= 8'hFF;
      served     <= 1'b0;
      rom_wr_err <= 1'b0;
      dl_busy    <= 1'b0;
      dl_overrun <= 1'b0;
      dl_addr_q  <= '0;
      dl_data_q  <= '0;
    end else begin
      state      <= state_nx;
      mem_req    <= req_nx;
      mem_we     <= we_nx;
      mem_addr   <= addr_nx;
      mem_wdata  <= wdata_nx;
      din_q      <= din_nx;
      served     <= served_nx;
      rom_wr_err <= rom_err_nx;
      dl_busy    <= busy_nx;
      dl_overrun <= overrun_nx;
      if (dl_accept) begin
        dl_addr_q <= dl_addr;
        dl_data_q <= dl_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_laser_bank_mapper.sv
`default_nettype none
// ============================================================================
// Module      : tb_laser_bank_mapper
// Description : Self-checking bench for laser_bank_mapper. A 4-slot default
//               build is checked against a slot/memory model every cycle; an
//               8-slot, 8-RAM-page build checks the wider window.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_laser_bank_mapper;

  localparam int AW = 25;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          we;
    logic [7:0]    wdata;
  } req_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [15:0]   cpu_addr = '0;
  logic [7:0]    cpu_dout = '0;
  logic          cpu_mreq_n = 1'b1, cpu_iorq_n = 1'b1, cpu_rd_n = 1'b1;
  logic          cpu_wr_n = 1'b1, cpu_m1_n = 1'b1;
  logic [7:0]    cpu_din;
  logic          cpu_wait_n, io_sel;
  logic          dl_wr = 1'b0;
  logic [AW-1:0] dl_addr = '0;
  logic [7:0]    dl_data = '0;
  logic          dl_busy, dl_overrun;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic          rom_wr_err;

  logic [7:0]    cpu_din8, mem_wdata8;
  logic          cpu_wait_n8, io_sel8, dl_busy8, dl_overrun8;
  logic          mem_req8, mem_we8, rom_wr_err8;
  logic [AW-1:0] mem_addr8;
  logic          mem_ack8 = 1'b0;

  always #5 clk = ~clk;

  laser_bank_mapper dut (
    .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .cpu_mreq_n(cpu_mreq_n), .cpu_iorq_n(cpu_iorq_n), .cpu_rd_n(cpu_rd_n),
    .cpu_wr_n(cpu_wr_n), .cpu_m1_n(cpu_m1_n), .cpu_din(cpu_din),
    .cpu_wait_n(cpu_wait_n), .io_sel(io_sel), .dl_wr(dl_wr), .dl_addr(dl_addr),
    .dl_data(dl_data), .dl_busy(dl_busy), .dl_overrun(dl_overrun),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .rom_wr_err(rom_wr_err)
  );

  laser_bank_mapper #(.NUM_SLOTS(8), .RAM_PAGES(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .cpu_mreq_n(cpu_mreq_n), .cpu_iorq_n(cpu_iorq_n), .cpu_rd_n(cpu_rd_n),
    .cpu_wr_n(cpu_wr_n), .cpu_m1_n(cpu_m1_n), .cpu_din(cpu_din8),
    .cpu_wait_n(cpu_wait_n8), .io_sel(io_sel8), .dl_wr(1'b0), .dl_addr('0),
    .dl_data(8'h00), .dl_busy(dl_busy8), .dl_overrun(dl_overrun8),
    .mem_req(mem_req8), .mem_we(mem_we8), .mem_addr(mem_addr8),
    .mem_wdata(mem_wdata8), .mem_rdata(8'h00), .mem_ack(mem_ack8),
    .rom_wr_err(rom_wr_err8)
  );

  // ---------------- model / scoreboard state ----------------
  int         errors = 0;
  int         checks = 0;
  logic [3:0] model_page [4];
  logic [7:0] model_mem [int];
  req_t       exp_q [$];
  req_t       last_req;
  req_t       prev_vals;
  logic       prev_req = 1'b0;
  bit         auto_ack = 1'b1;
  int         ack_lat = 0;
  int         lat_cnt = 0;
  int         rom_pulses = 0, ovr_pulses = 0, req_count = 0, rom8_pulses = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Physical address from the slot model: page * 16K + offset.
  function automatic logic [AW-1:0] model_phys(input logic [15:0] a);
    int s;
    s = int'(a) / 16384;
    return AW'(int'(model_page[s]) * 16384 + int'(a) % 16384);
  endfunction

  function automatic bit model_is_ram(input logic [15:0] a);
    int p;
    p = int'(model_page[int'(a) / 16384]);
    return (p >= 4) && (p < 8);
  endfunction

  function automatic logic [7:0] mem_read(input logic [AW-1:0] a);
    if (model_mem.exists(int'(a))) return model_mem[int'(a)];
    return a[7:0] ^ 8'h5A;
  endfunction

  // One clock, then the per-cycle compare and SDRAM responder at the negedge.
  task automatic tick();
    req_t e;
    bit   exp_io;
    int   p;
    @(posedge clk);
    @(negedge clk);
    if (mem_req && !prev_req) begin
      req_count++;
      last_req = '{mem_addr, mem_we, mem_wdata};
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_req: got addr %0h, required no request", mem_addr);
      end else begin
        e = exp_q.pop_front();
        check("req_addr", 64'(mem_addr), 64'(e.addr));
        check("req_we", 64'(mem_we), 64'(e.we));
        if (e.we) check("req_wdata", 64'(mem_wdata), 64'(e.wdata));
      end
    end else if (mem_req && prev_req) begin
      check("req_stable", 64'({mem_addr, mem_we, mem_wdata}), 64'(prev_vals));
    end
    p = int'(cpu_addr[7:0]) - 64;
    exp_io = !cpu_iorq_n && !cpu_rd_n && cpu_m1_n && (p >= 0) && (p < 4);
    check("io_sel", 64'(io_sel), 64'(exp_io));
    if (exp_io) check("io_rdata", 64'(cpu_din), 64'({4'h0, model_page[p]}));
    if (rom_wr_err)  rom_pulses++;
    if (dl_overrun)  ovr_pulses++;
    if (rom_wr_err8) rom8_pulses++;
    prev_req  = mem_req;
    prev_vals = '{mem_addr, mem_we, mem_wdata};
    if (mem_ack) mem_ack = 1'b0;
    else if (mem_req && auto_ack) begin
      if (lat_cnt >= ack_lat) begin
        mem_ack = 1'b1;
        lat_cnt = 0;
        if (mem_we) model_mem[int'(mem_addr)] = mem_wdata;
        else        mem_rdata = mem_read(mem_addr);
      end else lat_cnt++;
    end
    mem_ack8 = mem_req8 && !mem_ack8;
  endtask

  task automatic cpu_mem(input logic [15:0] a, input bit we, input logic [7:0] d,
                         input bit with_dl, input logic [AW-1:0] da, input logic [7:0] dd,
                         output int n);
    bit         ram;
    logic [7:0] exp_rd;
    int         rom0;
    ram    = model_is_ram(a);
    exp_rd = mem_read(model_phys(a));
    rom0   = rom_pulses;
    if (with_dl) begin
      dl_wr = 1'b1; dl_addr = da; dl_data = dd;
      exp_q.push_back('{da, 1'b1, dd});
    end
    if (!(we && !ram)) exp_q.push_back('{model_phys(a), we, d});
    cpu_addr = a; cpu_dout = d; cpu_mreq_n = 1'b0;
    cpu_rd_n = we; cpu_wr_n = !we;
    #1 check("wait_detect", 64'(cpu_wait_n), 64'(0));
    n = 0;
    do begin
      tick();
      dl_wr = 1'b0;
      n++;
    end while (!cpu_wait_n && n < 64);
    check("wait_budget", 64'(n < 64), 64'(1));
    if (we && !ram) check("rom_wait_cycles", 64'(n), 64'(1));
    else begin
      check("req_done", 64'(exp_q.size()), 64'(0));
      if (!we) check("rd_data", 64'(cpu_din), 64'(exp_rd));
    end
    cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1;
    tick();
    check("rom_pulses", 64'(rom_pulses - rom0), 64'((we && !ram) ? 1 : 0));
    if (!we) check("rd_hold", 64'(cpu_din), 64'(exp_rd));
  endtask

  // The data byte changes after the first cycle; only the first value may load.
  task automatic io_out(input logic [7:0] port, input logic [7:0] v);
    cpu_addr = {8'h00, port}; cpu_dout = v;
    cpu_iorq_n = 1'b0; cpu_wr_n = 1'b0;
    #1 check("io_wait_out", 64'(cpu_wait_n), 64'(1));
    tick();
    model_page[int'(port) - 64] = v[3:0];
    cpu_dout = v ^ 8'h0F;
    tick();
    cpu_iorq_n = 1'b1; cpu_wr_n = 1'b1;
    tick();
  endtask

  task automatic io_in(input logic [7:0] port, output logic [7:0] v, output logic sel);
    cpu_addr = {8'h00, port};
    cpu_iorq_n = 1'b0; cpu_rd_n = 1'b0;
    #1 check("io_wait_in", 64'(cpu_wait_n), 64'(1));
    v = cpu_din; sel = io_sel;
    tick();
    cpu_iorq_n = 1'b1; cpu_rd_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int         n, r0, o0;
    logic [7:0] v;
    logic       sel, seen8, we8;
    logic [AW-1:0] a8;
    for (int i = 0; i < 4; i++) model_page[i] = 4'h0;
    model_mem[32'h123] = 8'hA5;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_mem_req", 64'(mem_req), 64'(0));
    check("rst_mem_we", 64'(mem_we), 64'(0));
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    check("rst_cpu_din", 64'(cpu_din), 64'(8'hFF));
    check("rst_wait_n", 64'(cpu_wait_n), 64'(1));
    check("rst_flags", 64'({io_sel, dl_busy, dl_overrun, rom_wr_err}), 64'(0));
    reset_n = 1'b1;
    tick();

    // Plain read through page 0
    cpu_mem(16'h0123, 1'b0, 8'h00, 1'b0, '0, 8'h00, n);
    check("t1_addr", 64'(last_req.addr), 64'(25'h000123));
    check("t1_we", 64'(last_req.we), 64'(0));
    check("t1_din", 64'(cpu_din), 64'(8'hA5));
    check("t1_wait_cycles", 64'(n), 64'(2));

    // Slot 1 -> page 5, RAM write and readback
    io_out(8'h41, 8'h05);
    cpu_mem(16'h4010, 1'b1, 8'h3C, 1'b0, '0, 8'h00, n);
    check("t2_addr", 64'(last_req.addr), 64'(25'h014010));
    check("t2_we", 64'(last_req.we), 64'(1));
    check("t2_wdata", 64'(last_req.wdata), 64'(8'h3C));
    io_in(8'h41, v, sel);
    check("t2_io_din", 64'(v), 64'(8'h05));
    check("t2_io_sel", 64'(sel), 64'(1));
    io_in(8'h44, v, sel);
    check("t2_io_miss", 64'(sel), 64'(0));
    cpu_mem(16'h4010, 1'b0, 8'h00, 1'b0, '0, 8'h00, n);
    check("t2_readback", 64'(cpu_din), 64'(8'h3C));

    // ROM write suppressed
    r0 = req_count;
    cpu_mem(16'h0000, 1'b1, 8'h11, 1'b0, '0, 8'h00, n);
    check("t3_no_req", 64'(req_count - r0), 64'(0));

    // RAM window edges: pages 4 and 7 writable, 3 and 8 protected
    io_out(8'h42, 8'h04);
    cpu_mem(16'h8001, 1'b1, 8'h44, 1'b0, '0, 8'h00, n);
    io_out(8'h43, 8'h07);
    cpu_mem(16'hFFFF, 1'b1, 8'h77, 1'b0, '0, 8'h00, n);
    check("edge7_addr", 64'(last_req.addr), 64'(25'h01FFFF));
    io_out(8'h42, 8'h03);
    cpu_mem(16'h8001, 1'b1, 8'h33, 1'b0, '0, 8'h00, n);
    io_out(8'h43, 8'h08);
    cpu_mem(16'hC000, 1'b1, 8'h88, 1'b0, '0, 8'h00, n);

    // Download and CPU read in the same cycle: download first
    r0 = req_count;
    cpu_mem(16'h4010, 1'b0, 8'h00, 1'b1, 25'h1000, 8'h77, n);
    check("t4_reqs", 64'(req_count - r0), 64'(2));
    check("t4_wait_cycles", 64'(n), 64'(4));
    check("t4_dl_data", 64'(model_mem.exists(32'h1000) ? model_mem[32'h1000] : 8'h00), 64'(8'h77));
    check("t4_din", 64'(cpu_din), 64'(8'h3C));

    // Back-to-back downloads with slow ack
    ack_lat = 5;
    r0 = req_count; o0 = ovr_pulses;
    exp_q.push_back('{25'h0002000, 1'b1, 8'hA1});
    dl_wr = 1'b1; dl_addr = 25'h2000; dl_data = 8'hA1;
    tick();
    check("t5_busy_set", 64'(dl_busy), 64'(1));
    dl_addr = 25'h2001; dl_data = 8'hA2;
    tick();
    dl_wr = 1'b0;
    check("t5_overrun", 64'(dl_overrun), 64'(1));
    n = 0;
    while (dl_busy && n < 32) begin tick(); n++; end
    tick();
    check("t5_ovr_count", 64'(ovr_pulses - o0), 64'(1));
    check("t5_busy_clear", 64'(dl_busy), 64'(0));
    check("t5_reqs", 64'(req_count - r0), 64'(1));
    check("t5_stored", 64'(model_mem.exists(32'h2000) ? model_mem[32'h2000] : 8'h00), 64'(8'hA1));
    check("t5_dropped", 64'(model_mem.exists(32'h2001)), 64'(0));
    ack_lat = 0;

    // Reset in CPU_WAIT
    auto_ack = 1'b0;
    exp_q.push_back('{25'h0000123, 1'b0, 8'h00});
    cpu_addr = 16'h0123; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
    repeat (3) tick();
    check("t6_req_pending", 64'(mem_req), 64'(1));
    check("t6_wait_low", 64'(cpu_wait_n), 64'(0));
    reset_n = 1'b0;
    #1;
    check("t6_rst_req", 64'(mem_req), 64'(0));
    check("t6_rst_wait", 64'(cpu_wait_n), 64'(1));
    check("t6_rst_din", 64'(cpu_din), 64'(8'hFF));
    cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1;
    for (int i = 0; i < 4; i++) model_page[i] = 4'h0;
    tick();
    reset_n = 1'b1;
    tick();
    mem_rdata = 8'h5A; mem_ack = 1'b1;
    tick();
    tick();
    check("t6_stray_din", 64'(cpu_din), 64'(8'hFF));
    check("t6_stray_req", 64'(mem_req), 64'(0));
    io_in(8'h41, v, sel);
    check("t6_slot_clear", 64'(v), 64'(8'h00));
    auto_ack = 1'b1;

    // 8-slot build: page 11 writable, page 12 protected (slot 1 = 0x2000)
    for (int k = 0; k < 2; k++) begin
      io_out(8'h41, (k == 0) ? 8'd11 : 8'd12);
      r0 = rom8_pulses;
      seen8 = 1'b0; a8 = '0; we8 = 1'b0;
      cpu_addr = 16'h2010; cpu_dout = 8'h99; cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0;
      n = 0;
      do begin
        tick();
        if (mem_req8 && !seen8) begin seen8 = 1'b1; a8 = mem_addr8; we8 = mem_we8; end
        n++;
      end while (!cpu_wait_n8 && n < 32);
      cpu_mreq_n = 1'b1; cpu_wr_n = 1'b1;
      tick();
      if (k == 0) begin
        check("t7_p11_req", 64'(seen8), 64'(1));
        check("t7_p11_addr", 64'(a8), 64'(25'h016010));
        check("t7_p11_we", 64'(we8), 64'(1));
        check("t7_p11_rom", 64'(rom8_pulses - r0), 64'(0));
      end else begin
        check("t7_p12_req", 64'(seen8), 64'(0));
        check("t7_p12_rom", 64'(rom8_pulses - r0), 64'(1));
        check("t7_p12_wait", 64'(n), 64'(1));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/laser_bank_mapper.md
Name: laser_bank_mapper

Overview:
- Parametrised memory mapper and SDRAM request sequencer for the Laser 350/500/700 cores.
- Sits between the T80s bus, the data_io download path and the sdram controller; replaces the fixed 4-slot inline bank logic.
- Adds four things the inline logic lacks:
  - I/O-writable and readable slot registers.
  - Per-model RAM windows with ROM write protection.
  - A req/ack handshake that drives Z80 WAIT_n.
  - Download-priority arbitration with a one-entry holding buffer.

Parameters:
- NUM_SLOTS, 4: CPU address slots (power of 2, 2..16); SLOT_BITS = log2(NUM_SLOTS), OFS_BITS = 16-SLOT_BITS.
- PAGE_BITS, 4: page register width.
- PHYS_ADDR_W, 25: physical address width; must be >= PAGE_BITS+OFS_BITS.
- RAM_FIRST_PAGE, 4: lowest writable page.
- RAM_PAGES, 4: number of writable pages (350=1, 500=4, 700=8).
- IO_PORT_BASE, 8'h40: slot i register sits at I/O port IO_PORT_BASE+i.

Ports:
- clk  in  1  system clock (CPUCK domain)
- reset_n  in  1  asynchronous active-low reset
- cpu_addr  in  16  Z80 address
- cpu_dout  in  8  Z80 write data
- cpu_mreq_n  in  1  Z80 MREQ_n
- cpu_iorq_n  in  1  Z80 IORQ_n
- cpu_rd_n  in  1  Z80 RD_n
- cpu_wr_n  in  1  Z80 WR_n
- cpu_m1_n  in  1  Z80 M1_n (IORQ with M1 = interrupt acknowledge, ignored)
- cpu_din  out  8  read data to Z80
- cpu_wait_n  out  1  Z80 WAIT_n
- io_sel  out  1  high when this block drives cpu_din for an I/O read
- dl_wr  in  1  data_io write strobe, one cycle
- dl_addr  in  PHYS_ADDR_W  download address
- dl_data  in  8  download byte
- dl_busy  out  1  holding buffer occupied
- dl_overrun  out  1  one-cycle pulse: dl_wr while dl_busy
- mem_req  out  1  SDRAM request, level
- mem_we  out  1  request is a write
- mem_addr  out  PHYS_ADDR_W  request address
- mem_wdata  out  8  request write data
- mem_rdata  in  8  SDRAM read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion
- rom_wr_err  out  1  one-cycle pulse: CPU write to non-RAM page suppressed

Behaviour:
Reset:
- Asynchronous and active-low: clock is clk, reset is reset_n, asynchronous active-low.
- All slot registers = 0; FSM = IDLE.
- mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; cpu_din=8'hFF; cpu_wait_n=1; io_sel=0.
- dl_busy=0, dl_overrun=0, rom_wr_err=0.
- Reset mid-transaction abandons it; any late mem_ack is ignored.

Address mapping:
- slot = cpu_addr[15:OFS_BITS].
- phys = zero-extend {page[slot], cpu_addr[OFS_BITS-1:0]} to PHYS_ADDR_W.
- is_ram = (page >= RAM_FIRST_PAGE) && (page < RAM_FIRST_PAGE+RAM_PAGES), compared at PAGE_BITS+1 width so there is no wrap.

I/O:
- An I/O write (iorq_n=0, wr_n=0, m1_n=1) to port cpu_addr[7:0] in [IO_PORT_BASE, IO_PORT_BASE+NUM_SLOTS-1] loads cpu_dout[PAGE_BITS-1:0] into that slot register.
- The load happens once per IORQ assertion, on the first qualifying cycle.
- An I/O read to the same ports sets io_sel=1 combinationally and returns cpu_din = {zero pad, page}.
- I/O never raises WAIT.

Memory access detect:
- access = mreq_n=0 && (rd_n=0 || wr_n=0) && !served, where served is set on completion and cleared when mreq_n=1.
- cpu_wait_n = !(access && state != DONE), combinational, so WAIT drops in the detect cycle.

FSM:
- IDLE:
  - If dl_busy: issue the download write (mem_req=1, mem_we=1, mem_addr=held address, mem_wdata=held data), go to DL_WAIT.
  - Else if access && wr_n=0 && !is_ram: pulse rom_wr_err, set served, go to DONE with no SDRAM cycle.
  - Else if access: issue mem_req with phys and we=!wr_n, go to CPU_WAIT.
- DL_WAIT:
  - mem_req and mem_* stay stable until mem_ack.
  - On ack: drop mem_req and clear dl_busy, then go to IDLE.
  - A CPU access is serviced next, so download has priority.
- CPU_WAIT:
  - mem_req and mem_* stay stable until mem_ack.
  - On ack: drop mem_req and set served.
  - On a read, latch mem_rdata into cpu_din; cpu_din then holds until the next completed read.
  - Go to DONE.
- DONE: cpu_wait_n=1; return to IDLE when mreq_n=1.

Download buffer:
- dl_wr with dl_busy=0 latches dl_addr/dl_data and sets dl_busy on the next edge.
- dl_wr with dl_busy=1 drops the new byte and pulses dl_overrun.
- dl_wr in the same cycle that the buffer clears (ack in DL_WAIT) is accepted.

Decomposition:
- Package laser_mem_pkg:
  - FSM state enum {IDLE, DL_WAIT, CPU_WAIT, DONE}.
  - Model constants for RAM_FIRST_PAGE/RAM_PAGES per 350/500/700.
  - Default IO_PORT_BASE.
- One sub-module, laser_slot_regs: the slot register file, I/O decode and readback.
- The FSM, arbitration and download buffer stay in the top.

Test Plan:
- Reset, then read 16'h0123 -> mem_addr=25'h000123, mem_we=0, WAIT low until ack; mem_rdata=8'hA5 -> cpu_din=8'hA5, cpu_wait_n=1 the cycle after ack.
- OUT (0x41),5 then write 8'h3C to 16'h4010 -> mem_addr=25'h014010, mem_we=1, mem_wdata=8'h3C; IN (0x41) -> cpu_din=8'h05, io_sel=1.
- Slot 0 = page 0, write 16'h0000 -> no mem_req, rom_wr_err one pulse, WAIT never held past the detect cycle.
- dl_wr(25'h1000, 8'h77) in the same cycle as a CPU read detect -> download issued first, CPU request follows its ack, CPU WAIT held throughout.
- Two dl_wr back-to-back with mem_ack delayed 5 cycles -> second dropped, dl_overrun=1 for one cycle, dl_busy clears on ack.
- reset_n low during CPU_WAIT -> mem_req=0 and cpu_wait_n=1 immediately, slot registers=0; a subsequent stray mem_ack does not change cpu_din (8'hFF).
- NUM_SLOTS=8, RAM_PAGES=8 build: page 11 writable, page 12 write -> rom_wr_err.
